skolem_sweep_checker: RTL and testbench

- Sequential exhaustive checker that sits directly downstream of a combinational Skolem-function block for the invertibility problem "x bvudiv s <s t".
- Enumerates every (s, t) pair, drives them into the Skolem block, and captures its candidate x.
- Uses an iterative divider to decide whether the candidate satisfies the constraint, and brute-forces whether any x exists.
- Reports pass/fail counts and the first counterexample.

---
 rtl/skolem_sweep_checker.sv | 251 +++++++++++++++++++++++++
 tb/tb_skolem_sweep_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/skolem_sweep_checker.sv
// -----------------------------------------------------------------------------
// skolem_sweep_checker
//
// Exhaustive checker placed downstream of a combinational Skolem-function block
// for the invertibility problem "x bvudiv s <s t". Every (s, t) pair is driven
// out on s_o/t_o, the Skolem candidate is captured from x_i, and a restoring
// divider decides whether the candidate satisfies the constraint. When it does
// not, every x is brute-forced to decide whether a solution existed at all.
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset (aborts a sweep, clears results)
//   start     pulse; begins a sweep when idle, ignored while busy
//   s_o       divisor driven to the Skolem block
//   t_o       bound driven to the Skolem block
//   x_i       candidate returned by the Skolem block
//   busy      high from the cycle after an accepted start until done
//   done      one-cycle pulse at sweep completion
//   pass      valid from done until next start: no failures were found
//   sat_cnt   number of pairs for which some x satisfies the constraint
//   fail_cnt  number of pairs with a solution that the candidate misses
//   ff_s/t/x  first failing pair and its captured candidate
// -----------------------------------------------------------------------------
module skolem_sweep_checker #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [W-1:0]   s_o,
  output logic [W-1:0]   t_o,
  input  logic [W-1:0]   x_i,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   sat_cnt,
  output logic [2*W:0]   fail_cnt,
  output logic [W-1:0]   ff_s,
  output logic [W-1:0]   ff_t,
  output logic [W-1:0]   ff_x
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]   V_ZERO   = W'(0);
  localparam logic [W-1:0]   V_ONE    = W'(1);
  localparam logic [W-1:0]   V_ONES   = {W{1'b1}};
  localparam logic [2*W:0]   C_ZERO   = (2*W+1)'(0);
  localparam logic [2*W:0]   C_ONE    = (2*W+1)'(1);
  localparam logic [2*W-1:0] IDX_ZERO = (2*W)'(0);
  localparam logic [2*W-1:0] IDX_ONE  = (2*W)'(1);
  localparam logic [2*W-1:0] IDX_LAST = {(2*W){1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_DIVX  = 3'd2,
    S_CHKX  = 3'd3,
    S_SRCH  = 3'd4,
    S_CHKC  = 3'd5,
    S_NEXT  = 3'd6
  } state_t;

  state_t          r_state;
  logic [2*W-1:0]  r_idx;      // {t, s}: s increments fastest
  logic [W-1:0]    r_xs;       // captured Skolem candidate
  logic [W-1:0]    r_cand;     // brute-force search candidate
  logic [W-1:0]    r_dvd;      // dividend, shifted out MSB first
  logic [W-1:0]    r_rem;      // partial remainder
  logic [W-1:0]    r_quo;      // quotient, built MSB first
  logic [CW-1:0]   r_cnt;      // divider step counter
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [2*W:0]    r_sat;
  logic [2*W:0]    r_fail;
  logic [W-1:0]    r_ff_s;
  logic [W-1:0]    r_ff_t;
  logic [W-1:0]    r_ff_x;

  logic [W-1:0]    w_s;
  logic [W-1:0]    w_t;
  logic [W:0]      w_rem_sh;
  logic [W-1:0]    w_diff;
  logic            w_ge;
  logic [W-1:0]    w_rem_nx;
  logic [W-1:0]    w_quo_nx;
  logic            w_div_last;
  logic            w_lt;

  assign w_s = r_idx[W-1:0];
  assign w_t = r_idx[2*W-1:W];

  assign s_o      = w_s;
  assign t_o      = w_t;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign sat_cnt  = r_sat;
  assign fail_cnt = r_fail;
  assign ff_s     = r_ff_s;
  assign ff_t     = r_ff_t;
  assign ff_x     = r_ff_x;

  // One restoring-division step and the signed satisfaction compare.
  always_comb begin
    w_rem_sh = {r_rem, r_dvd[W-1]};
    // When w_ge holds the true difference is below s, so the low W bits suffice.
    w_diff   = w_rem_sh[W-1:0] - w_s;
    w_ge     = (w_rem_sh >= {1'b0, w_s});
    if (w_ge) begin
      w_rem_nx = w_diff;
    end else begin
      w_rem_nx = w_rem_sh[W-1:0];
    end
    w_quo_nx   = {r_quo[W-2:0], w_ge};
    w_div_last = (r_cnt == CNT_LAST);
    w_lt       = ($signed(r_quo) < $signed(w_t));
  end

  // Sweep controller, divider datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= IDX_ZERO;
      r_xs    <= V_ZERO;
      r_cand  <= V_ZERO;
      r_dvd   <= V_ZERO;
      r_rem   <= V_ZERO;
      r_quo   <= V_ZERO;
      r_cnt   <= CNT_ZERO;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_sat   <= C_ZERO;
      r_fail  <= C_ZERO;
      r_ff_s  <= V_ZERO;
      r_ff_t  <= V_ZERO;
      r_ff_x  <= V_ZERO;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start coinciding with the done pulse is deliberately not accepted.
          if (start && !r_done) begin
            r_idx   <= IDX_ZERO;
            r_sat   <= C_ZERO;
            r_fail  <= C_ZERO;
            r_ff_s  <= V_ZERO;
            r_ff_t  <= V_ZERO;
            r_ff_x  <= V_ZERO;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_APPLY;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_APPLY: begin
          // s_o/t_o have been stable for a full cycle; the Skolem block is combinational.
          r_xs    <= x_i;
          r_dvd   <= x_i;
          r_rem   <= V_ZERO;
          r_quo   <= V_ZERO;
          r_cnt   <= CNT_ZERO;
          r_state <= S_DIVX;
        end

        S_DIVX, S_SRCH: begin
          if (w_s == V_ZERO) begin
            // Division by zero yields all-ones without running the divider.
            r_quo   <= V_ONES;
            r_state <= (r_state == S_DIVX) ? S_CHKX : S_CHKC;
          end else begin
            r_rem <= w_rem_nx;
            r_dvd <= {r_dvd[W-2:0], 1'b0};
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + CNT_ONE;
            if (w_div_last) begin
              r_state <= (r_state == S_DIVX) ? S_CHKX : S_CHKC;
            end else begin
              r_state <= r_state;
            end
          end
        end

        S_CHKX: begin
          if (w_lt) begin
            r_sat   <= r_sat + C_ONE;
            r_state <= S_NEXT;
          end else begin
            r_cand  <= V_ZERO;
            r_dvd   <= V_ZERO;
            r_rem   <= V_ZERO;
            r_quo   <= V_ZERO;
            r_cnt   <= CNT_ZERO;
            r_state <= S_SRCH;
          end
        end

        S_CHKC: begin
          if (w_lt) begin
            // A solution exists that the Skolem candidate missed.
            r_sat  <= r_sat + C_ONE;
            r_fail <= r_fail + C_ONE;
            if (r_fail == C_ZERO) begin
              r_ff_s <= w_s;
              r_ff_t <= w_t;
              r_ff_x <= r_xs;
            end else begin
              r_ff_s <= r_ff_s;
            end
            r_state <= S_NEXT;
          end else if (r_cand == V_ONES) begin
            // Search exhausted: no solution, which is not a failure.
            r_state <= S_NEXT;
          end else begin
            r_cand  <= r_cand + V_ONE;
            r_dvd   <= r_cand + V_ONE;
            r_rem   <= V_ZERO;
            r_quo   <= V_ZERO;
            r_cnt   <= CNT_ZERO;
            r_state <= S_SRCH;
          end
        end

        S_NEXT: begin
          if (r_idx == IDX_LAST) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pass  <= (r_fail == C_ZERO);
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + IDX_ONE;
            r_state <= S_APPLY;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_skolem_sweep_checker
//
// Drives skolem_sweep_checker with a behavioural Skolem block (either a
// correct witness search or a stub returning zero) and checks the sweep
// results against a reference computed directly from the constraint.
// -----------------------------------------------------------------------------
module tb_skolem_sweep_checker;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   s_o, t_o, x_i;
  logic           busy, done, pass;
  logic [2*W:0]   sat_cnt, fail_cnt;
  logic [W-1:0]   ff_s, ff_t, ff_x;

  int mode = 0;          // 0: correct Skolem block, 1: stub returning 0
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  bit prev_busy = 1'b0;

  int         exp_sat, exp_fail;
  logic [3:0] exp_fs, exp_ft, exp_fx;

  always #5 clk = ~clk;

  // x udiv s (all-ones for s==0), compared signed against t
  function automatic bit sat_fn(input logic [3:0] x, input logic [3:0] s, input logic [3:0] t);
    logic [3:0] q;
    q = (s == 4'd0) ? 4'hF : (x / s);
    return $signed(q) < $signed(t);
  endfunction

  function automatic bit exists_fn(input logic [3:0] s, input logic [3:0] t);
    for (int i = 0; i < 16; i++) begin
      if (sat_fn(4'(i), s, t)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] skolem(input int m, input logic [3:0] s, input logic [3:0] t);
    if (m == 1) return 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (sat_fn(4'(i), s, t)) return 4'(i);
    end
    return 4'd0;
  endfunction

  assign x_i = skolem(mode, s_o, t_o);

  task automatic model_sweep(input int m, output int sat, output int fail,
                             output logic [3:0] fs, output logic [3:0] ft, output logic [3:0] fx);
    logic [7:0] iv;
    logic [3:0] s, t, x;
    sat = 0; fail = 0; fs = 4'd0; ft = 4'd0; fx = 4'd0;
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      s = iv[3:0];
      t = iv[7:4];
      x = skolem(m, s, t);
      if (sat_fn(x, s, t)) begin
        sat++;
      end else if (exists_fn(s, t)) begin
        if (fail == 0) begin fs = s; ft = t; fx = x; end
        sat++;
        fail++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic set_expect(input int m);
    model_sweep(m, exp_sat, exp_fail, exp_fs, exp_ft, exp_fx);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk("done_reached", done_cnt, target);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_sat"}, sat_cnt, 0);
    chk({tag, "_fail"}, fail_cnt, 0);
    chk({tag, "_s_o"}, s_o, 0);
    chk({tag, "_t_o"}, t_o, 0);
    chk({tag, "_ff"}, {ff_s, ff_t, ff_x}, 0);
  endtask

  skolem_sweep_checker #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_o(s_o), .t_o(t_o), .x_i(x_i),
    .busy(busy), .done(done), .pass(pass),
    .sat_cnt(sat_cnt), .fail_cnt(fail_cnt),
    .ff_s(ff_s), .ff_t(ff_t), .ff_x(ff_x)
  );

  // Result checker: every done pulse must carry the modelled sweep results.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) begin
        done_cnt++;
        chk("done_busy_low", busy, 0);
        chk("busy_before_done", prev_busy, 1);
        chk("sat_cnt", sat_cnt, exp_sat);
        chk("fail_cnt", fail_cnt, exp_fail);
        chk("pass", pass, (exp_fail == 0) ? 1 : 0);
        chk("ff_s", ff_s, exp_fs);
        chk("ff_t", ff_t, exp_ft);
        chk("ff_x", ff_x, exp_fx);
      end
      prev_busy = busy;
    end
  end

  initial begin
    int         msat, mfail;
    logic [3:0] mfs, mft, mfx;
    int         n;

    rst_n = 1'b0;
    start = 1'b0;

    // Pin the reference model with hand-derived numbers.
    model_sweep(0, msat, mfail, mfs, mft, mfx);
    chk("model_correct_sat", msat, 121);
    chk("model_correct_fail", mfail, 0);
    model_sweep(1, msat, mfail, mfs, mft, mfx);
    chk("model_stub_sat", msat, 121);
    chk("model_stub_fail", mfail, 8);
    chk("model_stub_ff", {mfs, mft, mfx}, {4'd1, 4'd0, 4'd0});
    chk("spot_s0_t0", sat_fn(4'd0, 4'd0, 4'd0), 1);
    chk("spot_s3_t8", exists_fn(4'd3, 4'd8), 0);
    chk("spot_s1_t9", sat_fn(4'd8, 4'd1, 4'd9), 1);

    // Reset state, then idle with no start.
    repeat (3) @(posedge clk);
    #1 chk_all_zero("in_reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("idle_no_done", done_cnt, 0);
    chk_all_zero("idle");

    // Sweep with a correct Skolem block.
    set_expect(0);
    pulse_start();
    wait_done(1);
    repeat (5) @(negedge clk);
    chk("pass_held", pass, 1);
    chk("sat_held", sat_cnt, 121);

    // Sweep with the stub returning zero.
    mode = 1;
    set_expect(1);
    pulse_start();
    wait_done(2);
    repeat (3) @(negedge clk);
    chk("stub_pass_held", pass, 0);

    // Abort a sweep at pair index 100.
    mode = 0;
    set_expect(0);
    pulse_start();
    n = 0;
    while ({t_o, s_o} != 8'd100 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_idx100", {t_o, s_o}, 100);
    chk("pre_abort_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("abort");
    @(negedge clk) rst_n = 1'b1;
    chk("no_done_on_abort", done_cnt, 2);

    // New sweep after abort, with a start pulse while busy.
    pulse_start();
    repeat (50) @(negedge clk);
    chk("busy_mid_sweep", busy, 1);
    pulse_start();
    wait_done(3);
    repeat (200) @(negedge clk);
    chk("single_done", done_cnt, 3);
    chk("idle_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
